mix_muldiv: RTL

//   Multi-cycle sign-magnitude multiply/divide unit for the MIX core (MUL opcode 3, DIV opcode 4).

---
 rtl/mix_muldiv_pkg.sv | 17 +
 rtl/mix_muldiv_if.sv | 26 ++
 rtl/mix_muldiv.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mix_muldiv_pkg.sv
// Shared definitions for the MIX multiply/divide unit: word layout, opcodes
// and the sequencer state encoding.
package mix_pkg;

   localparam int MIX_MAG = 30;
   localparam int SIGN    = MIX_MAG;

   localparam logic [5:0] OP_MUL = 6'd3;
   localparam logic [5:0] OP_DIV = 6'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

endpackage

// File: rtl/mix_muldiv_if.sv
// Request/result bundle between the core's execute stage and mix_muldiv.
// The core side is the master; the arithmetic unit is the slave.
interface mix_muldiv_if #(parameter int MAG = mix_pkg::MIX_MAG);

   logic           start;
   logic           op;
   logic [MAG:0]   a_in;
   logic [MAG:0]   x_in;
   logic [MAG:0]   v_in;
   logic           busy;
   logic           done;
   logic [MAG:0]   a_out;
   logic [MAG:0]   x_out;
   logic           ovf;

   modport master (
      output start, op, a_in, x_in, v_in,
      input  busy, done, a_out, x_out, ovf
   );

   modport slave (
      input  start, op, a_in, x_in, v_in,
      output busy, done, a_out, x_out, ovf
   );

endinterface

// File: rtl/mix_muldiv.sv
// Sign-magnitude MUL (shift-add) / DIV (restoring) unit for the MIX core.
// One MAG+1-bit adder is shared: it adds |V| for MUL and trial-subtracts |V| for DIV.
module mix_muldiv
   import mix_pkg::*;
#(
   parameter int MAG = MIX_MAG
) (
   input  logic         clk,
   input  logic         reset,
   mix_muldiv_if.slave  bus
);

   localparam int CW = $clog2(MAG);

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            isDiv;
   logic            sA;
   logic            sRes;
   logic [MAG-1:0]  vMag;
   logic [MAG:0]    rem;
   logic [MAG-1:0]  quo;

   logic [MAG:0]    opA;
   logic [MAG+1:0]  sum;
   logic            ge;
   logic [MAG:0]    mulHi;
   logic [MAG:0]    nextRem;
   logic [MAG-1:0]  nextQuo;
   logic [MAG-1:0]  aMagIn;
   logic [MAG-1:0]  vMagIn;
   logic            divOvf;

   // rem/quo hold {hi,lo} of the product for MUL and {R,Q} for DIV.
   // A clear top bit of the MAG+2-bit sum means the trial subtract did not borrow.
   always_comb begin
      opA     = isDiv ? {rem[MAG-1:0], quo[MAG-1]} : rem;
      sum     = {1'b0, opA}
              + (isDiv ? ~{2'b00, vMag} : {2'b00, vMag})
              + {{(MAG+1){1'b0}}, isDiv};
      ge      = ~sum[MAG+1];
      mulHi   = quo[0] ? sum[MAG:0] : rem;
      nextRem = rem;
      nextQuo = quo;
      if (isDiv) begin
         nextRem = ge ? sum[MAG:0] : opA;
         nextQuo = {quo[MAG-2:0], ge};
      end else begin
         nextRem = {1'b0, mulHi[MAG:1]};
         nextQuo = {mulHi[0], quo[MAG-1:1]};
      end
   end

   assign aMagIn = bus.a_in[MAG-1:0];
   assign vMagIn = bus.v_in[MAG-1:0];
   assign divOvf = bus.op && ((vMagIn == '0) || (aMagIn >= vMagIn));

   // Sequencer: a DIV overflow skips the iterations and returns the inputs unchanged.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         isDiv     <= 1'b0;
         sA        <= 1'b0;
         sRes      <= 1'b0;
         vMag      <= '0;
         rem       <= '0;
         quo       <= '0;
         bus.busy  <= 1'b0;
         bus.done  <= 1'b0;
         bus.ovf   <= 1'b0;
         bus.a_out <= '0;
         bus.x_out <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  isDiv    <= bus.op;
                  sA       <= bus.a_in[MAG];
                  sRes     <= bus.a_in[MAG] ^ bus.v_in[MAG];
                  vMag     <= vMagIn;
                  rem      <= bus.op ? {1'b0, aMagIn} : '0;
                  quo      <= bus.op ? bus.x_in[MAG-1:0] : aMagIn;
                  cnt      <= CW'(MAG - 1);
                  bus.busy <= 1'b1;
                  if (divOvf) begin
                     state     <= FIN;
                     bus.done  <= 1'b1;
                     bus.ovf   <= 1'b1;
                     bus.a_out <= bus.a_in;
                     bus.x_out <= bus.x_in;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               rem <= nextRem;
               quo <= nextQuo;
               if (cnt == '0) begin
                  state    <= FIN;
                  bus.done <= 1'b1;
                  bus.ovf  <= 1'b0;
                  if (isDiv) begin
                     bus.a_out <= {sRes, nextQuo};
                     bus.x_out <= {sA, nextRem[MAG-1:0]};
                  end else begin
                     bus.a_out <= {sRes, nextRem[MAG-1:0]};
                     bus.x_out <= {sRes, nextQuo};
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            FIN: begin
               state    <= IDLE;
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
